bdpsk_tx_ctrl: RTL and testbench

BDPSK_TX_CTRL -- requirements
Module: bdpsk_tx_ctrl

---
 rtl/bdpsk_tx_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_bdpsk_tx_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bdpsk_tx_ctrl.sv
// -----------------------------------------------------------------------------
// bdpsk_tx_ctrl
//
// Byte-serial transmit controller for a differential BPSK modulator. Bytes are
// accepted through a valid/ready handshake and sent MSB first, one bit per
// symbol of N clock cycles. Each symbol's carrier phase is the previous phase
// XOR the new bit (0 = 0 deg, 1 = 180 deg).
//
// Optional feature (compile-time macro BDPSK_TX_PREAMBLE_EN):
//   defined   - every frame that starts from IDLE is preceded by PRE_LEN
//               symbols of '1' (state PRE, counter pre_cnt).
//   undefined - no PRE state; IDLE goes directly to DATA; PRE_LEN unused.
//
// Parameters:
//   N        clock cycles per symbol, 2..1024
//   PRE_LEN  preamble length in symbols, 1..64
//
// Ports:
//   clk       in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   in_data   in   [7:0] byte to send, sampled only on handshake
//   in_valid  in   in_data valid
//   in_ready  out  byte accepted this cycle when in_valid is also high
//   sym_tick  out  one-cycle pulse on the last cycle of every symbol
//   tx_bit    out  raw bit of the current symbol (0 when idle)
//   tx_phase  out  differentially encoded phase, holds its value when idle
//   busy      out  high whenever the controller is not idle
// -----------------------------------------------------------------------------
module bdpsk_tx_ctrl #(
  parameter int N       = 128,
  parameter int PRE_LEN = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       sym_tick,
  output logic       tx_bit,
  output logic       tx_phase,
  output logic       busy
);

  // Parameter legality is checked at elaboration so an illegal build fails
  // loudly instead of producing a mis-sized counter.
  if (N < 2 || N > 1024) begin : g_bad_n
    $error("bdpsk_tx_ctrl: N must be in 2..1024");
  end
  if (PRE_LEN < 1 || PRE_LEN > 64) begin : g_bad_pre_len
    $error("bdpsk_tx_ctrl: PRE_LEN must be in 1..64");
  end

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

`ifdef BDPSK_TX_PREAMBLE_EN
  localparam int            PW       = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_byte;
  logic          r_tx_bit;
  logic          r_tx_phase;
`ifdef BDPSK_TX_PREAMBLE_EN
  logic [PW-1:0] r_pre_cnt;
`endif

  logic w_sym_end;    // last cycle of the current symbol
  logic w_handshake;
  logic w_sym_load;   // a new symbol starts next cycle
  logic w_sym_bit;    // raw bit of that new symbol
  logic w_byte_load;
  logic w_go_idle;

  assign w_sym_end   = (r_state != S_IDLE) && (r_cnt == CNT_LAST);
  // The ready window inside DATA is the very last cycle of a byte, which lets
  // a back-to-back byte start with no idle gap.
  assign in_ready    = (r_state == S_IDLE) ||
                       ((r_state == S_DATA) && (r_bit_idx == 3'd7) && w_sym_end);
  assign w_handshake = in_valid && in_ready;
  assign sym_tick    = w_sym_end;
  assign busy        = (r_state != S_IDLE);
  assign tx_bit      = r_tx_bit;
  assign tx_phase    = r_tx_phase;

  // ---------------------------------------------------------------------------
  // Next-state and symbol-load decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case statement leaves a signal unassigned (which would
    // infer a latch).
    w_state_nxt = r_state;
    w_sym_load  = 1'b0;
    w_sym_bit   = 1'b0;
    w_byte_load = 1'b0;
    w_go_idle   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_handshake) begin
          w_byte_load = 1'b1;
          w_sym_load  = 1'b1;
`ifdef BDPSK_TX_PREAMBLE_EN
          w_state_nxt = S_PRE;
          w_sym_bit   = 1'b1;
`else
          w_state_nxt = S_DATA;
          w_sym_bit   = in_data[7];
`endif
        end
      end

`ifdef BDPSK_TX_PREAMBLE_EN
      S_PRE: begin
        if (w_sym_end) begin
          w_sym_load = 1'b1;
          if (r_pre_cnt == PRE_LAST) begin
            w_state_nxt = S_DATA;
            w_sym_bit   = r_byte[7];
          end else begin
            w_sym_bit   = 1'b1;
          end
        end
      end
`endif

      S_DATA: begin
        if (w_sym_end) begin
          if (r_bit_idx != 3'd7) begin
            w_sym_load = 1'b1;
            w_sym_bit  = r_byte[3'd6 - r_bit_idx];
          end else if (w_handshake) begin
            // Chained byte: no preamble, continue straight into its MSB.
            w_byte_load = 1'b1;
            w_sym_load  = 1'b1;
            w_sym_bit   = in_data[7];
          end else begin
            w_state_nxt = S_IDLE;
            w_go_idle   = 1'b1;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Counters and symbol outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_bit_idx  <= 3'd0;
      r_tx_bit   <= 1'b0;
      r_tx_phase <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_sym_end) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;

      // bit_idx wraps 7 -> 0 at the end of a byte, which is also the value
      // wanted on a chained byte or on return to IDLE.
      if (r_state == S_DATA && w_sym_end) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_sym_load) begin
        r_tx_bit   <= w_sym_bit;
        r_tx_phase <= r_tx_phase ^ w_sym_bit;
      end else if (w_go_idle) begin
        r_tx_bit   <= 1'b0;
      end
    end
  end

`ifdef BDPSK_TX_PREAMBLE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
    end else if (r_state == S_PRE && w_sym_end) begin
      if (r_pre_cnt == PRE_LAST) r_pre_cnt <= '0;
      else                       r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end
`endif

  // NOTE: the byte holding register is pure datapath and is always written
  // before it is read after a handshake, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_byte_load) r_byte <= in_data;
  end

endmodule

// File: tb/tb_bdpsk_tx_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for bdpsk_tx_ctrl (N = 4, PRE_LEN = 8). A symbol-queue
// reference model predicts every output on every cycle; directed scenarios add
// literal checks of bit/phase sequences, tick counts and busy durations.
// -----------------------------------------------------------------------------
module tb_bdpsk_tx_ctrl;

  localparam int N       = 4;
  localparam int PRE_LEN = 8;
`ifdef BDPSK_TX_PREAMBLE_EN
  localparam bit PRE_EN  = 1'b1;
`else
  localparam bit PRE_EN  = 1'b0;
`endif
  localparam int PRE_SYM = PRE_EN ? PRE_LEN : 0;
  localparam int PRE_CYC = PRE_SYM * N;
  localparam logic [4:0] RESET_VEC = 5'b10000; // {ready,tick,bit,phase,busy}

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, sym_tick, tx_bit, tx_phase, busy;

  always #5 clk = ~clk;

  bdpsk_tx_ctrl #(.N(N), .PRE_LEN(PRE_LEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sym_tick(sym_tick),
    .tx_bit  (tx_bit),
    .tx_phase(tx_phase),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // Reference model: a queue of pending symbol bits and the number of cycles
  // left in the symbol on air.
  // ---------------------------------------------------------------------------
  bit m_busy, m_bit, m_phase;
  int m_left;
  int m_acc;
  bit q[$];

  function automatic bit m_ready();
    return !m_busy || (q.size() == 0 && m_left == 1);
  endfunction

  function automatic logic [4:0] exp_vec();
    return {m_ready(), (m_busy && m_left == 1), m_bit, m_phase, m_busy};
  endfunction

  function automatic logic [4:0] obs_vec();
    return {in_ready, sym_tick, tx_bit, tx_phase, busy};
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy  = 1'b0;
    m_bit   = 1'b0;
    m_phase = 1'b0;
    m_left  = 0;
  endtask

  task automatic model_step();
    bit hs;
    hs = in_valid && m_ready();
    if (m_busy && m_left > 1) begin
      m_left--;
    end else begin
      if (hs) begin
        m_acc++;
        if (!m_busy) for (int i = 0; i < PRE_SYM; i++) q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) q.push_back(in_data[i]);
      end
      if (q.size() > 0) begin
        m_bit   = q.pop_front();
        m_phase = m_phase ^ m_bit;
        m_left  = N;
        m_busy  = 1'b1;
      end else begin
        m_busy = 1'b0;
        m_bit  = 1'b0;
      end
    end
  endtask

  // Drive inputs (at the falling edge), clock once, then sample at the next
  // falling edge.
  task automatic run_cycle(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_err++;
      $display("FAIL reset_hold got=%b want=%b", obs_vec(), RESET_VEC);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 8'($urandom));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  // One byte from idle with phase starting at 0; checks every cycle plus the
  // data bits and phases seen at each data symbol's tick.
  task automatic test_single_byte(input logic [7:0] b, input logic [7:0] want_ph,
                                  input string name);
    int         ticks  = 0;
    int         busy_c = 0;
    logic [7:0] bits   = '0;
    logic [7:0] ph     = '0;
    for (int i = 0; i < 8 * N + PRE_CYC + 4; i++) begin
      run_cycle(i == 0, (i == 0) ? b : 8'($urandom));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL %s_cycle cyc=%0d got=%b want=%b", name, i, obs_vec(), exp_vec());
      end
      if (sym_tick) begin
        ticks++;
        bits = {bits[6:0], tx_bit};
        ph   = {ph[6:0], tx_phase};
      end
      if (busy) busy_c++;
    end
    n_cmp++;
    if (ticks !== 8 + PRE_SYM) begin
      n_err++;
      $display("FAIL %s_ticks got=%0d want=%0d", name, ticks, 8 + PRE_SYM);
    end
    n_cmp++;
    if (busy_c !== 8 * N + PRE_CYC) begin
      n_err++;
      $display("FAIL %s_busy got=%0d want=%0d", name, busy_c, 8 * N + PRE_CYC);
    end
    n_cmp++;
    if (bits !== b) begin
      n_err++;
      $display("FAIL %s_bits got=%h want=%h", name, bits, b);
    end
    n_cmp++;
    if (ph !== want_ph) begin
      n_err++;
      $display("FAIL %s_phase got=%b want=%b", name, ph, want_ph);
    end
  endtask

  // 0xFF then 0x00 with in_valid held high: no gap, second byte chained.
  task automatic test_back_to_back();
    int   base    = m_acc;
    int   toggles = 0;
    int   busy_c  = 0;
    int   win     = -1;
    logic prev_ph = tx_phase;
    for (int i = 0; i < 16 * N + PRE_CYC + 6; i++) begin
      run_cycle((m_acc - base) < 2, ((m_acc - base) == 0) ? 8'hFF : 8'h00);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b_cycle cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
      if (tx_phase !== prev_ph) toggles++;
      prev_ph = tx_phase;
      if (busy) busy_c++;
      if (win < 0 && in_ready && busy) win = i;
    end
    n_cmp++;
    if (win !== 8 * N - 1 + PRE_CYC) begin
      n_err++;
      $display("FAIL b2b_window got=%0d want=%0d", win, 8 * N - 1 + PRE_CYC);
    end
    n_cmp++;
    if (toggles !== 8 + PRE_SYM) begin
      n_err++;
      $display("FAIL b2b_toggles got=%0d want=%0d", toggles, 8 + PRE_SYM);
    end
    n_cmp++;
    if (busy_c !== 16 * N + PRE_CYC) begin
      n_err++;
      $display("FAIL b2b_busy got=%0d want=%0d", busy_c, 16 * N + PRE_CYC);
    end
  endtask

  // Random valid/data for 200 accepted bytes, all checked cycle by cycle.
  task automatic test_random();
    int base = m_acc;
    int cyc  = 0;
    while ((m_acc - base) < 200 && cyc < 40000) begin
      run_cycle(1'($urandom_range(0, 1)), 8'($urandom));
      cyc++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cycle cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ((m_acc - base) < 200) begin
      n_err++;
      $display("FAIL random_budget got=%0d want=200 bytes", m_acc - base);
    end
    for (int i = 0; i < 8 * N + PRE_CYC + 4; i++) begin
      run_cycle(1'b0, 8'($urandom));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_drain cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  // Reset pulsed during bit 3 of 0x3C; then 0x01 must start from phase 0.
  task automatic test_reset_mid_byte();
    for (int i = 0; i < PRE_CYC + 3 * N + 2; i++) begin
      run_cycle(i == 0, (i == 0) ? 8'h3C : 8'($urandom));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL midrst_cycle cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_err++;
      $display("FAIL midrst_async got=%b want=%b", obs_vec(), RESET_VEC);
    end
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (obs_vec() !== RESET_VEC) begin
      n_err++;
      $display("FAIL midrst_hold got=%b want=%b", obs_vec(), RESET_VEC);
    end
    reset_n = 1'b1;
    @(negedge clk);
    test_single_byte(8'h01, 8'h01, "after_rst");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    m_acc = 0;
    test_reset();
    test_single_byte(8'hA5, 8'hC6, "byte_a5");
    test_back_to_back();
    test_single_byte(8'h80, 8'hFF, "byte_80");
    test_random();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
